// File: rtl/conv_bank_scheduler_pkg.sv
// Shared constants and types for the ping-pong image-RAM scheduler of the
// stride-2 3x3 convolution path.
package conv_sched_pkg;

    localparam int IMG_W   = 9;
    localparam int K       = 3;
    localparam int STRIDE  = 2;
    localparam int OUT_W   = 4;
    localparam int BANK_SZ = 81;
    localparam int TAPS    = 9;
    localparam int AW      = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        RELEASE = 2'd2
    } rd_state_t;

    // Bank 1 starts right after the 81 pixels of bank 0.
    function automatic logic [AW-1:0] bank_base(input logic bank);
        return bank ? AW'(BANK_SZ) : '0;
    endfunction

endpackage

// File: rtl/conv_bank_scheduler_if.sv
// Pixel-write and tap-read bundle between the upstream source / MAC stage
// (master) and the bank scheduler (slave).
interface conv_bank_scheduler_if;
    import conv_sched_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          mac_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          tap_valid;
    logic [3:0]    tap_idx;
    logic          win_last;
    logic          img_last;
    logic [1:0]    bank_full;

    modport master (
        output in_valid, mac_ready,
        input  in_ready, wr_en, wr_addr, rd_en, rd_addr,
               tap_valid, tap_idx, win_last, img_last, bank_full
    );

    modport slave (
        input  in_valid, mac_ready,
        output in_ready, wr_en, wr_addr, rd_en, rd_addr,
               tap_valid, tap_idx, win_last, img_last, bank_full
    );

endinterface

// File: rtl/conv_bank_scheduler_window_addr_gen.sv
// Walks the 16 stride-2 windows x 9 taps of one bank and forms the RAM read
// address; counters move only when the scheduler issues a tap.
module window_addr_gen
    import conv_sched_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    input  logic          bank,
    output logic [AW-1:0] addr,
    output logic [3:0]    tap_idx,
    output logic          win_last,
    output logic          img_last
);

    localparam logic [1:0] TAP_MAX = 2'(K - 1);
    localparam logic [1:0] OUT_MAX = 2'(OUT_W - 1);

    logic [1:0] tcol_q, tcol_d;
    logic [1:0] trow_q, trow_d;
    logic [1:0] ocol_q, ocol_d;
    logic [1:0] orow_q, orow_d;
    logic [AW-1:0] row, col;

    // Final tap rolls every counter back to zero, ready for the next bank.
    always_comb begin
        tcol_d = tcol_q;
        trow_d = trow_q;
        ocol_d = ocol_q;
        orow_d = orow_q;
        if (advance) begin
            if (tcol_q == TAP_MAX) begin
                tcol_d = '0;
                if (trow_q == TAP_MAX) begin
                    trow_d = '0;
                    if (ocol_q == OUT_MAX) begin
                        ocol_d = '0;
                        orow_d = (orow_q == OUT_MAX) ? 2'd0 : orow_q + 2'd1;
                    end else begin
                        ocol_d = ocol_q + 2'd1;
                    end
                end else begin
                    trow_d = trow_q + 2'd1;
                end
            end else begin
                tcol_d = tcol_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcol_q <= '0;
            trow_q <= '0;
            ocol_q <= '0;
            orow_q <= '0;
        end else begin
            tcol_q <= tcol_d;
            trow_q <= trow_d;
            ocol_q <= ocol_d;
            orow_q <= orow_d;
        end
    end

    always_comb begin
        row      = AW'(orow_q) * AW'(STRIDE) + AW'(trow_q);
        col      = AW'(ocol_q) * AW'(STRIDE) + AW'(tcol_q);
        addr     = bank_base(bank) + row * AW'(IMG_W) + col;
        tap_idx  = 4'(trow_q) * 4'(K) + 4'(tcol_q);
        win_last = (tcol_q == TAP_MAX) && (trow_q == TAP_MAX);
        img_last = win_last && (ocol_q == OUT_MAX) && (orow_q == OUT_MAX);
    end

endmodule

// File: rtl/conv_bank_scheduler.sv
// Ping-pong bank scheduler: fills banks from the raster pixel stream and
// replays each full bank to the MAC stage as 3x3 window read addresses.
module conv_bank_scheduler
    import conv_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    conv_bank_scheduler_if.slave bus
);

    localparam logic [6:0] WLAST = 7'(BANK_SZ - 1);

    logic [6:0] wcount_q, wcount_d;
    logic       wr_bank_q, wr_bank_d;
    logic [1:0] bank_full_q, bank_full_d;
    logic       rd_bank_q, rd_bank_d;
    rd_state_t  state_q, state_d;
    logic       in_ready, wr_en, rd_en;
    logic          tap_valid_q, win_last_q, img_last_q;
    logic [3:0]    tap_idx_q;
    logic [AW-1:0] gen_addr;
    logic [3:0]    gen_tap_idx;
    logic          gen_win_last, gen_img_last;

    window_addr_gen u_gen (
        .clk      (clk),
        .reset    (reset),
        .advance  (rd_en),
        .bank     (rd_bank_q),
        .addr     (gen_addr),
        .tap_idx  (gen_tap_idx),
        .win_last (gen_win_last),
        .img_last (gen_img_last)
    );

    always_comb begin
        in_ready  = !bank_full_q[wr_bank_q];
        wr_en     = bus.in_valid && in_ready;
        wcount_d  = wcount_q;
        wr_bank_d = wr_bank_q;
        if (wr_en) begin
            if (wcount_q == WLAST) begin
                wcount_d  = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wcount_d = wcount_q + 7'd1;
            end
        end
    end

    // Writer sets only empty banks and RELEASE clears only the full one being
    // read, so both updates can land in the same cycle on different banks.
    always_comb begin
        bank_full_d = bank_full_q;
        if (wr_en && (wcount_q == WLAST))
            bank_full_d[wr_bank_q] = 1'b1;
        if (state_q == RELEASE)
            bank_full_d[rd_bank_q] = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bank_full_q[rd_bank_q])
                    state_d = READ;
            end
            READ: begin
                rd_en = bus.mac_ready;
                if (rd_en && gen_img_last)
                    state_d = RELEASE;
            end
            RELEASE: begin
                rd_bank_d = ~rd_bank_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcount_q    <= '0;
            wr_bank_q   <= 1'b0;
            bank_full_q <= '0;
            rd_bank_q   <= 1'b0;
            state_q     <= IDLE;
        end else begin
            wcount_q    <= wcount_d;
            wr_bank_q   <= wr_bank_d;
            bank_full_q <= bank_full_d;
            rd_bank_q   <= rd_bank_d;
            state_q     <= state_d;
        end
    end

    // Sideband lags rd_en by one cycle to line up with RAM read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap_valid_q <= 1'b0;
            tap_idx_q   <= '0;
            win_last_q  <= 1'b0;
            img_last_q  <= 1'b0;
        end else begin
            tap_valid_q <= rd_en;
            tap_idx_q   <= gen_tap_idx;
            win_last_q  <= rd_en && gen_win_last;
            img_last_q  <= rd_en && gen_img_last;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.wr_en     = wr_en;
    assign bus.wr_addr   = bank_base(wr_bank_q) + AW'(wcount_q);
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = gen_addr;
    assign bus.tap_valid = tap_valid_q;
    assign bus.tap_idx   = tap_idx_q;
    assign bus.win_last  = win_last_q;
    assign bus.img_last  = img_last_q;
    assign bus.bank_full = bank_full_q;

endmodule

// File: tb/tb_conv_bank_scheduler.sv
// Directed bench for conv_bank_scheduler: fill, stall, drain, alternation
// and mid-image reset.
module tb_conv_bank_scheduler;
    import conv_sched_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    conv_bank_scheduler_if bus();

    conv_bank_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Window tap n (0..143) of a bank, derived from the raster geometry.
    function automatic int exp_rd(input int bank, input int n);
        int orow, ocol, trow, tcol;
        orow = n / 36;
        ocol = (n / 9) % 4;
        trow = (n % 9) / 3;
        tcol = n % 3;
        return bank * 81 + (orow * 2 + trow) * 9 + ocol * 2 + tcol;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_in_ready"},  bus.in_ready, 1);
        chk({pfx, "_wr_en"},     bus.wr_en, 0);
        chk({pfx, "_wr_addr"},   bus.wr_addr, 0);
        chk({pfx, "_rd_en"},     bus.rd_en, 0);
        chk({pfx, "_rd_addr"},   bus.rd_addr, 0);
        chk({pfx, "_tap_valid"}, bus.tap_valid, 0);
        chk({pfx, "_tap_idx"},   bus.tap_idx, 0);
        chk({pfx, "_win_last"},  bus.win_last, 0);
        chk({pfx, "_img_last"},  bus.img_last, 0);
        chk({pfx, "_bank_full"}, bus.bank_full, 0);
    endtask

    task automatic apply_reset(input string pfx);
        bus.in_valid  = 1'b0;
        bus.mac_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk_reset_vals(pfx);
        tick();
        reset = 1'b1;
    endtask

    // Issues one full bank; optional mac_ready toggling stalls every other cycle.
    task automatic read_bank(input int bank, input bit toggle);
        int n = 0;
        int cyc = 0;
        int tv = 0;
        int il = 0;
        int prev = -1;
        bit started = 1'b0;
        while (n < 144 && cyc < 1000) begin
            bus.mac_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            if (prev >= 0) begin
                chk("tap_valid", bus.tap_valid, 1);
                chk("tap_idx", bus.tap_idx, prev % 9);
                chk("win_last", bus.win_last, (prev % 9) == 8);
                chk("img_last", bus.img_last, prev == 143);
            end else begin
                chk("tap_valid_gap", bus.tap_valid, 0);
            end
            tv += int'(bus.tap_valid);
            il += int'(bus.img_last);
            if (started) chk("rd_en_follows_mac_ready", bus.rd_en, bus.mac_ready);
            if (bus.rd_en) begin
                started = 1'b1;
                chk("rd_addr", bus.rd_addr, exp_rd(bank, n));
                prev = n;
                n++;
            end else begin
                prev = -1;
            end
            tick();
            cyc++;
        end
        chk("read_issue_count", n, 144);
        bus.mac_ready = 1'b0;
        @(negedge clk);
        chk("release_rd_en", bus.rd_en, 0);
        chk("final_tap_valid", bus.tap_valid, 1);
        chk("final_tap_idx", bus.tap_idx, 8);
        chk("final_win_last", bus.win_last, 1);
        chk("final_img_last", bus.img_last, 1);
        tv += int'(bus.tap_valid);
        il += int'(bus.img_last);
        chk("tap_valid_count", tv, 144);
        chk("img_last_pulses", il, 1);
        tick();
    endtask

    initial begin
        int wn, rn, cyc;
        bit hit;
        bus.in_valid  = 1'b0;
        bus.mac_ready = 1'b0;
        #2;
        apply_reset("por");

        // Fill both banks while the MAC stage is not ready.
        for (int i = 0; i < 162; i++) begin
            bus.in_valid = 1'b1;
            @(negedge clk);
            chk("fill_wr_en", bus.wr_en, 1);
            chk("fill_wr_addr", bus.wr_addr, i);
            chk("fill_rd_en", bus.rd_en, 0);
            if (i == 81) chk("bank0_full", bus.bank_full, 2'b01);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("both_full_in_ready", bus.in_ready, 0);
            chk("both_full_wr_en", bus.wr_en, 0);
            chk("both_full_flags", bus.bank_full, 2'b11);
            chk("both_full_rd_addr", bus.rd_addr, 0);
            tick();
        end

        // Drain bank 0 unstalled; the held pixel lands at address 0 afterwards.
        read_bank(0, 1'b0);
        @(negedge clk);
        chk("post_release_flags", bus.bank_full, 2'b10);
        chk("post_release_in_ready", bus.in_ready, 1);
        chk("post_release_wr_en", bus.wr_en, 1);
        chk("post_release_wr_addr", bus.wr_addr, 0);
        tick();
        bus.in_valid = 1'b0;

        // Drain bank 1 with mac_ready toggling every cycle.
        read_bank(1, 1'b1);

        // Four back-to-back images with everything ready.
        apply_reset("rst2");
        wn = 0; rn = 0; cyc = 0;
        while (rn < 576 && cyc < 3000) begin
            bus.in_valid  = (wn < 324);
            bus.mac_ready = 1'b1;
            @(negedge clk);
            chk("stream_wr_en", bus.wr_en, bus.in_valid && bus.in_ready);
            if (bus.wr_en) begin
                chk("stream_wr_addr", bus.wr_addr, ((wn / 81) % 2) * 81 + wn % 81);
                wn++;
            end
            if (bus.rd_en) begin
                chk("stream_rd_addr", bus.rd_addr, exp_rd((rn / 144) % 2, rn % 144));
                rn++;
            end
            tick();
            cyc++;
        end
        chk("stream_writes", wn, 324);
        chk("stream_reads", rn, 576);

        // Reset during the 40th bank-1 write and the 50th bank-0 read.
        apply_reset("rst3");
        bus.mac_ready = 1'b0;
        for (int i = 0; i < 81; i++) begin
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        wn = 0; rn = 0; cyc = 0; hit = 1'b0;
        while (!hit && cyc < 400) begin
            bus.mac_ready = 1'b1;
            bus.in_valid  = (rn >= 10);
            @(negedge clk);
            if (bus.rd_en && rn == 49) begin
                hit = 1'b1;
                chk("mid_write_active", bus.wr_en, 1);
                chk("mid_write_index", wn, 39);
                chk("mid_read_addr", bus.rd_addr, exp_rd(0, 49));
            end else begin
                if (bus.wr_en) begin
                    chk("mid_wr_addr", bus.wr_addr, 81 + wn);
                    wn++;
                end
                if (bus.rd_en) begin
                    chk("mid_rd_addr", bus.rd_addr, exp_rd(0, rn));
                    rn++;
                end
                tick();
            end
            cyc++;
        end
        chk("mid_reset_reached_read", rn, 49);
        bus.in_valid  = 1'b0;
        bus.mac_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        tick();
        chk_reset_vals("held_rst");
        reset = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("after_rst_wr_en", bus.wr_en, 1);
        chk("after_rst_wr_addr", bus.wr_addr, 0);
        chk("after_rst_bank_full", bus.bank_full, 2'b00);
        chk("after_rst_rd_en", bus.rd_en, 0);
        tick();
        bus.in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
